windowed_register_file: RTL

- Parametrised successor to the fixed 4-window SPARC register file: NWINDOWS register windows, 8 globals, CWP kept inside the block instead of in an external coupler.
- Sits between the ALU/operand muxes and the PSR logic.
- Performs SAVE/RESTORE with WIM-based overflow/underflow detection and direct CWP loads.
- Provides a multi-cycle scrub sequencer that zeroes every physical register.

---
 rtl/windowed_register_file.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/windowed_register_file.sv
// Windowed SPARC-style register file: NWINDOWS overlapping windows plus 8 globals,
// internal CWP with SAVE/RESTORE trap detection and a zeroing scrub sequencer.
// Optional same-cycle write-to-read forwarding when RF_WRITE_BYPASS_EN is defined.
module windowed_register_file #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          in_PA,
    input  logic [4:0]          in_PB,
    input  logic [4:0]          in_PC,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    out_PA,
    output logic [WIDTH-1:0]    out_PB,
    input  logic                save,
    input  logic                restore,
    input  logic [NWINDOWS-1:0] wim,
    input  logic                cwp_load,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic                scrub,
    output logic [CWP_W-1:0]    cwp,
    output logic                ovf,
    output logic                unf,
    output logic                cmd_err,
    output logic                busy
);
    localparam int               NPHYS  = 8 + 16 * NWINDOWS;
    localparam int               PW     = $clog2(NPHYS);
    localparam logic [PW-1:0]    LAST   = PW'(NPHYS - 1);
    localparam logic [CWP_W:0]   NW_EXT = (CWP_W + 1)'(NWINDOWS);
    localparam logic [CWP_W-1:0] TOP_W  = CWP_W'(NWINDOWS - 1);
    localparam logic [NWINDOWS-1:0] ONE = {{(NWINDOWS - 1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_SCRUB} state_t;

    logic [WIDTH-1:0] r_mem [NPHYS];
    state_t           r_state;
    logic [PW-1:0]    r_idx;
    logic [CWP_W-1:0] r_cwp;
    logic             r_busy, r_ovf, r_unf, r_err;

    logic [PW-1:0]    w_pa_phys, w_pb_phys, w_wr_phys;
    logic [CWP_W-1:0] w_save_t, w_rest_t;
    logic             w_save_hit, w_rest_hit, w_wr_ok, w_busy_cmd;

    // Outs and locals are contiguous per window; ins alias the next window's outs.
    function automatic logic [PW-1:0] f_phys(input logic [4:0] r, input logic [CWP_W-1:0] w);
        int wi, wn, p;
        wi = int'(w);
        wn = (wi == NWINDOWS - 1) ? 0 : wi + 1;
        if (r < 5'd8)       p = int'(r);
        else if (r < 5'd24) p = 16 * wi + int'(r);
        else                p = 16 * wn + int'(r) - 16;
        return PW'(p);
    endfunction

    assign w_pa_phys  = f_phys(in_PA, r_cwp);
    assign w_pb_phys  = f_phys(in_PB, r_cwp);
    assign w_wr_phys  = f_phys(in_PC, r_cwp);
    assign w_wr_ok    = wr_en && !r_busy && (in_PC != 5'd0);
    assign w_busy_cmd = wr_en || save || restore || cwp_load;

    assign w_save_t   = (r_cwp == '0) ? TOP_W : r_cwp - 1'b1;
    assign w_rest_t   = (r_cwp == TOP_W) ? '0 : r_cwp + 1'b1;
    assign w_save_hit = |(wim & (ONE << w_save_t));
    assign w_rest_hit = |(wim & (ONE << w_rest_t));

`ifdef RF_WRITE_BYPASS_EN
    assign out_PA = (in_PA == 5'd0) ? '0 :
                    (w_wr_ok && (w_wr_phys == w_pa_phys)) ? wr_data : r_mem[w_pa_phys];
    assign out_PB = (in_PB == 5'd0) ? '0 :
                    (w_wr_ok && (w_wr_phys == w_pb_phys)) ? wr_data : r_mem[w_pb_phys];
`else
    assign out_PA = (in_PA == 5'd0) ? '0 : r_mem[w_pa_phys];
    assign out_PB = (in_PB == 5'd0) ? '0 : r_mem[w_pb_phys];
`endif

    assign cwp     = r_cwp;
    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign cmd_err = r_err;
    assign busy    = r_busy;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < NPHYS; i++) r_mem[i] <= '0;
        end else if (r_state == S_SCRUB) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_wr_phys] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cwp   <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // cwp_load outranks SAVE/RESTORE; a rejected command leaves cwp alone.
                    if (cwp_load) begin
                        if ({1'b0, cwp_in} >= NW_EXT) r_err <= 1'b1;
                        else                          r_cwp <= cwp_in;
                    end else if (save && restore) begin
                        r_err <= 1'b1;
                    end else if (save) begin
                        if (w_save_hit) r_ovf <= 1'b1;
                        else            r_cwp <= w_save_t;
                    end else if (restore) begin
                        if (w_rest_hit) r_unf <= 1'b1;
                        else            r_cwp <= w_rest_t;
                    end
                    if (scrub) begin
                        r_state <= S_SCRUB;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_SCRUB: begin
                    if (w_busy_cmd) r_err <= 1'b1;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
